// File: rtl/postprocess_fmac_pack.sv
// FMAC post-processing: subnormal shift, rounding, overflow handling and IEEE-754 single packing.
// Optional subnormal support is built when FPU_PACK_DENORM_EN is defined; otherwise tiny results flush to zero.
package postprocess_fmac_pack_pkg;
    localparam int unsigned C_OP      = 32;
    localparam int unsigned C_EXP     = 8;
    localparam int unsigned C_MANT    = 23;
    localparam logic [7:0]  C_EXP_INF = 8'hFF;
    localparam int unsigned C_BIAS    = 127;
endpackage

module postprocess_fmac_pack
    import postprocess_fmac_pack_pkg::*;
(
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              In_Valid_SI,
    output logic              In_Ready_SO,
    input  logic              Sign_DI,
    input  logic [C_EXP+1:0]  Exp_DI,
    input  logic [C_MANT+3:0] Mant_DI,
    input  logic [1:0]        RM_SI,
    input  logic              NaN_SI,
    input  logic              Inf_SI,
    input  logic              Zero_SI,
    input  logic              Invalid_SI,
    output logic              Out_Valid_SO,
    input  logic              Out_Ready_SI,
    output logic [C_OP-1:0]   Result_DO,
    output logic [4:0]        Flags_SO
);
    localparam int unsigned EW = C_EXP + 2;
    localparam int unsigned MW = C_MANT + 4;
    localparam logic [EW-1:0] EXP_OVF = EW'(2 * C_BIAS + 1);

    typedef enum logic [1:0] {K_FIN, K_NAN, K_INF, K_ZERO} kind_e;
    typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RDN, RM_RUP} rm_e;

    logic            v1_q, v1_d, v2_q, v2_d, acc, adv;
    kind_e           kind1_q, kind1_d;
    rm_e             rm1_q, rm1_d;
    logic            sign1_q, nx1_q, nx1_d, uf1_q, uf1_d, nv1_q, nv1_d;
    logic [EW:0]     exp1_q, exp1_d;
    logic [C_MANT-1:0] frac1_q, frac1_d;
    logic [C_OP-1:0] res_q, res_d;
    logic [4:0]      flags_q, flags_d;

    logic            tiny, grs, inc, of, to_inf;
    logic [MW-1:0]   mant_sh;
    logic [C_MANT+1:0] sum;

    assign In_Ready_SO  = ~v1_q | ~v2_q | Out_Ready_SI;
    assign acc          = In_Valid_SI & In_Ready_SO;
    assign adv          = v1_q & (~v2_q | Out_Ready_SI);
    assign v1_d         = acc | (v1_q & ~adv);
    assign v2_d         = adv | (v2_q & ~Out_Ready_SI);
    assign Out_Valid_SO = v2_q;
    assign Result_DO    = res_q;
    assign Flags_SO     = flags_q;

    assign tiny = Exp_DI[EW-1] | (Exp_DI == '0);

`ifdef FPU_PACK_DENORM_EN
    localparam int unsigned SW = $clog2(MW + 1);
    localparam logic [EW:0] SH_MAX = (EW+1)'(MW);
    logic [EW:0]     sh_raw;
    logic [SW-1:0]   sh_amt;
    logic [2*MW-1:0] sh_wide;

    // Bits shifted below the sticky position collapse into sticky so rounding still sees them.
    always_comb begin
        sh_raw  = {{EW{1'b0}}, 1'b1} - {Exp_DI[EW-1], Exp_DI};
        sh_amt  = (sh_raw > SH_MAX) ? SW'(MW) : sh_raw[SW-1:0];
        sh_wide = {Mant_DI, {MW{1'b0}}} >> sh_amt;
        mant_sh = tiny ? {sh_wide[2*MW-1:MW+1], sh_wide[MW] | (|sh_wide[MW-1:0])} : Mant_DI;
    end
`else
    assign mant_sh = Mant_DI;
`endif

    always_comb begin
        kind1_d = K_FIN;
        if (NaN_SI || Invalid_SI) kind1_d = K_NAN;
        else if (Inf_SI)          kind1_d = K_INF;
        else if (Zero_SI)         kind1_d = K_ZERO;
        rm1_d = rm_e'(RM_SI);
        nv1_d = Invalid_SI;

        grs = mant_sh[2] | mant_sh[1] | mant_sh[0];
        unique case (rm1_d)
            RM_RNE:  inc = mant_sh[2] & (mant_sh[1] | mant_sh[0] | mant_sh[3]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = Sign_DI & grs;
            default: inc = ~Sign_DI & grs;
        endcase
        sum = {1'b0, mant_sh[MW-1:3]} + {{(C_MANT+1){1'b0}}, inc};

        // A rounded-up subnormal that reaches the hidden bit becomes exponent field 1.
        exp1_d  = tiny ? {{EW{1'b0}}, sum[C_MANT]}
                       : {Exp_DI[EW-1], Exp_DI} + {{EW{1'b0}}, sum[C_MANT+1]};
        frac1_d = sum[C_MANT+1] ? '0 : sum[C_MANT-1:0];
        nx1_d   = grs;
        uf1_d   = tiny & grs;
`ifndef FPU_PACK_DENORM_EN
        if (tiny) begin
            exp1_d  = '0;
            frac1_d = '0;
            nx1_d   = 1'b1;
            uf1_d   = 1'b1;
        end
`endif
    end

    always_comb begin
        of     = ~exp1_q[EW] & (exp1_q[EW-1:0] >= EXP_OVF);
        to_inf = (rm1_q == RM_RNE) | ((rm1_q == RM_RUP) & ~sign1_q) | ((rm1_q == RM_RDN) & sign1_q);
        res_d   = '0;
        flags_d = '0;
        unique case (kind1_q)
            K_NAN: begin
                res_d   = {1'b0, C_EXP_INF, 1'b1, {(C_MANT-1){1'b0}}};
                flags_d = {nv1_q, 4'b0000};
            end
            K_INF:  res_d = {sign1_q, C_EXP_INF, {C_MANT{1'b0}}};
            K_ZERO: res_d = {sign1_q, {(C_OP-1){1'b0}}};
            default: begin
                if (of) begin
                    res_d   = to_inf ? {sign1_q, C_EXP_INF, {C_MANT{1'b0}}}
                                     : {sign1_q, C_EXP_INF - 8'd1, {C_MANT{1'b1}}};
                    flags_d = 5'b00101;
                end else begin
                    res_d   = {sign1_q, exp1_q[C_EXP-1:0], frac1_q};
                    flags_d = {3'b000, uf1_q, nx1_q};
                end
            end
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            kind1_q <= K_FIN;
            rm1_q   <= RM_RNE;
            sign1_q <= 1'b0;
            nx1_q   <= 1'b0;
            uf1_q   <= 1'b0;
            nv1_q   <= 1'b0;
            exp1_q  <= '0;
            frac1_q <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (acc) begin
                kind1_q <= kind1_d;
                rm1_q   <= rm1_d;
                sign1_q <= Sign_DI;
                nx1_q   <= nx1_d;
                uf1_q   <= uf1_d;
                nv1_q   <= nv1_d;
                exp1_q  <= exp1_d;
                frac1_q <= frac1_d;
            end
            if (adv) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end
endmodule

// File: doc/postprocess_fmac_pack.md
POSTPROCESS_FMAC_PACK -- requirements
Module: postprocess_fmac_pack

Interface
REQ-001 SHALL use package constants C_OP=32, C_EXP=8, C_MANT=23, C_EXP_INF=8'hFF, C_BIAS=127.
REQ-002 SHALL have one clock and a synchronous, active-low reset: Clk_CI  in  1  clock, all state on rising edge.
REQ-003 Rst_RBI  in  1  synchronous active-low reset.
REQ-004 In_Valid_SI  in  1  input beat valid.
REQ-005 In_Ready_SO  out  1  block accepts beat this cycle.
REQ-006 Sign_DI  in  1  result sign.
REQ-007 Exp_DI  in  C_EXP+2  signed biased exponent, two's complement, may be <=0 or >=255.
REQ-008 Mant_DI  in  C_MANT+4  {hidden, 23 fraction, guard, round, sticky}; hidden=1 unless value zero.
REQ-009 RM_SI  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP.
REQ-010 NaN_SI / Inf_SI / Zero_SI / Invalid_SI  in  1 each  special-case flags from datapath.
REQ-011 Out_Valid_SO  out  1  result valid.
REQ-012 Out_Ready_SI  in  1  consumer accepts result.
REQ-013 Result_DO  out  C_OP  packed IEEE-754 single.
REQ-014 Flags_SO  out  5  {NV, DZ=0, OF, UF, NX}.

Function
REQ-015 Two-stage elastic pipeline: S1 = denormal shift + rounding, S2 = overflow check + packing; latency exactly 2 cycles with no backpressure; throughput 1 beat/cycle.
REQ-016 Beat accepted iff In_Valid_SI && In_Ready_SO; In_Ready_SO = ~V1 | ~V2 | Out_Ready_SI (combinational, no In_Valid dependency).
REQ-017 Output held stable (Result_DO, Flags_SO) while Out_Valid_SO && ~Out_Ready_SI; S1 advances into S2 only when S2 empty or draining.
REQ-018 Simultaneous accept and drain in a full pipe SHALL not lose or duplicate a beat.
REQ-019 Priority: NaN_SI/Invalid_SI > Inf_SI > Zero_SI > finite.
REQ-020 NaN or Invalid -> 32'h7FC00000, NV=Invalid_SI, other flags 0.
REQ-021 Inf -> {Sign,8'hFF,23'h0}, flags 0; Zero -> {Sign,31'h0}, flags 0.
REQ-022 Finite, Exp_DI<=0: right-shift Mant by 1-Exp_DI, shifted-out bits ORed into sticky, shift saturates at 27; exponent field 0.
REQ-023 Rounding: RNE inc=G&(R|S|L); RTZ inc=0; RDN inc=Sign&(G|R|S); RUP inc=~Sign&(G|R|S); NX=G|R|S.
REQ-024 Mantissa carry-out after rounding increments exponent and clears fraction; subnormal rounding to 2^-126 yields exponent field 1.
REQ-025 Final exponent >=255: OF=1, NX=1; RNE or (RUP&~Sign) or (RDN&Sign) -> Inf, else max finite {Sign,8'hFE,23'h7FFFFF}.
REQ-026 UF=1 iff result tiny before rounding (Exp_DI<=0) and NX=1.

Reset
REQ-027 On Rst_RBI=0 at clock edge: V1=V2=0, Out_Valid_SO=0, Result_DO=0, Flags_SO=0; in-flight beats discarded.
REQ-028 In_Ready_SO SHALL be 1 in the cycle after reset release; reset mid-operation drops both stages without emitting them.

Configuration
REQ-029 Macro FPU_PACK_DENORM_EN: defined -> REQ-022/REQ-024 subnormal path built.
REQ-030 Undefined -> any finite result with Exp_DI<=0 flushed to {Sign,31'h0} with UF=1, NX=1; shifter omitted.

Verification
REQ-031 Sign=0, Exp=127, Mant={1,23'h0,3'b000}, RNE -> 32'h3F800000, flags 0, Out_Valid 2 cycles after accept.
REQ-032 Exp=127, Mant all ones incl. G, RNE -> 32'h40000000, NX=1.
REQ-033 Exp=255, Mant normal, Sign=1, RTZ -> 32'hFF7FFFFF, OF=1, NX=1; same with RNE -> 32'hFF800000.
REQ-034 Exp=-1, Mant={1,23'h0,3'b000}, RNE, DENORM_EN -> 32'h00200000, flags 0; without macro -> 32'h00000000, UF=1, NX=1.
REQ-035 Invalid_SI=1 with Inf_SI=1 -> 32'h7FC00000, NV=1.
REQ-036 Stream 4 beats, Out_Ready_SI held 0 for 3 cycles then 1 -> In_Ready_SO drops after 2 beats stored, all 4 results emitted in order, none lost; assert Rst_RBI=0 mid-stream -> Out_Valid_SO=0 next cycle.
